// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle 32-bit MIPS core: PC, instruction ROM, 32x32 register file,
// ALU, extenders, data RAM and control decoder. Every instruction retires in
// one clock.
// Ports:
//   clk - system clock, all state updates on the rising edge
//   rst - asynchronous active-low reset (PC to TEXT_BASE, rf[1..31] cleared)

// Storage array for instruction words; the write port exists only so that
// the array has a driver and is tied off by the fetch wrapper.
// Ports: clk_i, we_i/waddr_i/wdata_i (preload port), raddr_i, rdata_c_o.
module mips_rom #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_c_o
);
  logic [31:0] ROM [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) ROM[waddr_i] <= wdata_i;
  end

  assign rdata_c_o = ROM[raddr_i];
endmodule

// Instruction fetch: maps byte PC onto ROM words; out-of-range PCs read 0 (NOP).
// Ports: clk_i, pc_i (byte address), inst_c_o (combinational instruction).
module mips_imem #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter int unsigned IM_DEPTH  = 1024
) (
  input  logic        clk_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_c_o
);
  localparam int unsigned AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;

  logic [31:0] off_c;
  logic [29:0] word_c;
  logic        hit_c;
  logic [31:0] rom_word_c;
  logic        unused_off_c;

  // PCs below TEXT_BASE wrap to huge offsets and fail the range check
  assign off_c        = pc_i - TEXT_BASE;
  assign word_c       = off_c[31:2];
  assign hit_c        = (32'(word_c) < IM_DEPTH);
  assign unused_off_c = ^off_c[1:0];

  mips_rom #(.DEPTH(IM_DEPTH), .AW(AW)) innerIM (
    .clk_i    (clk_i),
    .we_i     (1'b0),
    .waddr_i  ('0),
    .wdata_i  ('0),
    .raddr_i  (word_c[AW-1:0]),
    .rdata_c_o(rom_word_c)
  );

  assign inst_c_o = hit_c ? rom_word_c : 32'h0;
endmodule

// Word-wide data RAM, synchronous write and combinational read.
// Ports: clk_i, we_i, addr_i (word index), wdata_i, rdata_c_o.
module mips_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_c_o
);
  logic [31:0] dmem [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) dmem[addr_i] <= wdata_i;
  end

  assign rdata_c_o = dmem[addr_i];
endmodule

// Data memory wrapper: byte address to word index; out-of-range stores are
// dropped and loads return 0.
// Ports: clk_i, we_i, addr_i (byte address), wdata_i, rdata_c_o.
module mips_dmem #(
  parameter logic [31:0] DATA_BASE = 32'h0000_0000,
  parameter int unsigned DM_DEPTH  = 1024
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_c_o
);
  localparam int unsigned AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  logic [31:0] off_c;
  logic [29:0] word_c;
  logic        hit_c;
  logic [31:0] ram_word_c;
  logic        unused_off_c;

  assign off_c        = addr_i - DATA_BASE;
  assign word_c       = off_c[31:2];
  assign hit_c        = (32'(word_c) < DM_DEPTH);
  assign unused_off_c = ^off_c[1:0];

  mips_ram #(.DEPTH(DM_DEPTH), .AW(AW)) innerDM (
    .clk_i    (clk_i),
    .we_i     (we_i && hit_c),
    .addr_i   (word_c[AW-1:0]),
    .wdata_i  (wdata_i),
    .rdata_c_o(ram_word_c)
  );

  assign rdata_c_o = hit_c ? ram_word_c : 32'h0;
endmodule

// 32x32 register file: two combinational reads, one clocked write; $0 is hardwired.
// Ports: clk_i, rst_n_i, ra1_i/ra2_i -> rd1_c_o/rd2_c_o, we_i/wa_i/wd_i.
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_c_o,
  output logic [31:0] rd2_c_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] rf [0:31];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      rf[wa_i] <= wd_i;
    end
  end

  assign rd1_c_o = (ra1_i == 5'd0) ? 32'h0 : rf[ra1_i];
  assign rd2_c_o = (ra2_i == 5'd0) ? 32'h0 : rf[ra2_i];
endmodule

module mips_single_cycle_cpu #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] DATA_BASE = 32'h0000_0000,
  parameter int unsigned IM_DEPTH  = 1024,
  parameter int unsigned DM_DEPTH  = 1024
) (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [31:0] PC;
  logic [31:0] pc_d;
  logic [31:0] inst;

  logic [5:0]  op_c, funct_c;
  logic [4:0]  rs_c, rt_c, rd_c;
  logic [15:0] imm_c;
  logic [31:0] rs_val_c, rt_val_c, imm_sext_c, imm_zext_c;
  logic [31:0] pc_plus4_c, br_target_c, dm_addr_c, dm_rdata_c;
  logic        rf_we_c, dm_we_c;
  logic [4:0]  rf_wa_c;
  logic [31:0] rf_wd_c;
  logic        unused_shamt_c;

  assign op_c           = inst[31:26];
  assign rs_c           = inst[25:21];
  assign rt_c           = inst[20:16];
  assign rd_c           = inst[15:11];
  assign funct_c        = inst[5:0];
  assign imm_c          = inst[15:0];
  assign unused_shamt_c = ^inst[10:6];

  assign imm_sext_c  = {{16{imm_c[15]}}, imm_c};
  assign imm_zext_c  = {16'h0000, imm_c};
  assign pc_plus4_c  = PC + 32'd4;
  assign br_target_c = pc_plus4_c + {imm_sext_c[29:0], 2'b00};
  assign dm_addr_c   = rs_val_c + imm_sext_c;

  mips_imem #(.TEXT_BASE(TEXT_BASE), .IM_DEPTH(IM_DEPTH)) insMem (
    .clk_i   (clk),
    .pc_i    (PC),
    .inst_c_o(inst)
  );

  mips_regfile regFile (
    .clk_i  (clk),
    .rst_n_i(rst),
    .ra1_i  (rs_c),
    .ra2_i  (rt_c),
    .rd1_c_o(rs_val_c),
    .rd2_c_o(rt_val_c),
    .we_i   (rf_we_c),
    .wa_i   (rf_wa_c),
    .wd_i   (rf_wd_c)
  );

  // Stores are suppressed while reset is held even if the clock keeps running
  mips_dmem #(.DATA_BASE(DATA_BASE), .DM_DEPTH(DM_DEPTH)) dataMem (
    .clk_i    (clk),
    .we_i     (dm_we_c && rst),
    .addr_i   (dm_addr_c),
    .wdata_i  (rt_val_c),
    .rdata_c_o(dm_rdata_c)
  );

  // Decode + ALU: unsupported encodings fall through the defaults as NOPs
  always_comb begin
    rf_we_c = 1'b0;
    rf_wa_c = rt_c;
    rf_wd_c = 32'h0;
    dm_we_c = 1'b0;
    pc_d    = pc_plus4_c;
    case (op_c)
      OP_RTYPE: begin
        rf_wa_c = rd_c;
        case (funct_c)
          FN_ADD: begin rf_we_c = 1'b1; rf_wd_c = rs_val_c + rt_val_c; end
          FN_SUB: begin rf_we_c = 1'b1; rf_wd_c = rs_val_c - rt_val_c; end
          FN_AND: begin rf_we_c = 1'b1; rf_wd_c = rs_val_c & rt_val_c; end
          FN_OR:  begin rf_we_c = 1'b1; rf_wd_c = rs_val_c | rt_val_c; end
          FN_SLT: begin
            rf_we_c = 1'b1;
            rf_wd_c = ($signed(rs_val_c) < $signed(rt_val_c)) ? 32'd1 : 32'd0;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin rf_we_c = 1'b1; rf_wd_c = rs_val_c + imm_sext_c; end
      OP_ANDI: begin rf_we_c = 1'b1; rf_wd_c = rs_val_c & imm_zext_c; end
      OP_ORI:  begin rf_we_c = 1'b1; rf_wd_c = rs_val_c | imm_zext_c; end
      OP_LUI:  begin rf_we_c = 1'b1; rf_wd_c = {imm_c, 16'h0000}; end
      OP_LW:   begin rf_we_c = 1'b1; rf_wd_c = dm_rdata_c; end
      OP_SW:   dm_we_c = 1'b1;
      OP_BEQ:  if (rs_val_c == rt_val_c) pc_d = br_target_c;
      OP_J:    pc_d = {pc_plus4_c[31:28], inst[25:0], 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) PC <= TEXT_BASE;
    else      PC <= pc_d;
  end
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
module tb_mips_single_cycle_cpu;
  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] DATA_BASE = 32'h0000_0000;
  localparam int IM_DEPTH = 1024;
  localparam int DM_DEPTH = 1024;

  logic clk;
  logic rst;

  mips_single_cycle_cpu #(
    .TEXT_BASE(TEXT_BASE), .DATA_BASE(DATA_BASE),
    .IM_DEPTH(IM_DEPTH), .DM_DEPTH(DM_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [0:IM_DEPTH-1];
  logic [31:0] m_rf [0:31];
  logic [31:0] m_dm [0:DM_DEPTH-1];
  logic [31:0] m_pc;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  // Reference ISS: instruction-level semantics over plain arrays
  function automatic logic [31:0] fetch(input logic [31:0] pc);
    logic [31:0] off = pc - TEXT_BASE;
    logic [31:0] w = off >> 2;
    if (w < 32'(IM_DEPTH)) return prog[int'(w)];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = TEXT_BASE;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] ins = fetch(m_pc);
    logic [5:0]  op = ins[31:26];
    logic [5:0]  fn = ins[5:0];
    logic [4:0]  rs = ins[25:21];
    logic [4:0]  rt = ins[20:16];
    logic [4:0]  rd = ins[15:11];
    logic [15:0] imm = ins[15:0];
    logic [31:0] a = m_rf[rs];
    logic [31:0] b = m_rf[rt];
    logic [31:0] simm = {{16{imm[15]}}, imm};
    logic [31:0] zimm = {16'h0, imm};
    logic [31:0] nxt = m_pc + 32'd4;
    logic [31:0] ea = a + simm - DATA_BASE;
    logic [31:0] w = ea >> 2;
    logic        wen = 1'b0;
    logic [4:0]  widx = rt;
    logic [31:0] wval = 32'h0;
    case (op)
      6'h00: begin
        widx = rd;
        case (fn)
          6'h20: begin wen = 1'b1; wval = a + b; end
          6'h22: begin wen = 1'b1; wval = a - b; end
          6'h24: begin wen = 1'b1; wval = a & b; end
          6'h25: begin wen = 1'b1; wval = a | b; end
          6'h2A: begin wen = 1'b1; wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          default: ;
        endcase
      end
      6'h08: begin wen = 1'b1; wval = a + simm; end
      6'h0C: begin wen = 1'b1; wval = a & zimm; end
      6'h0D: begin wen = 1'b1; wval = a | zimm; end
      6'h0F: begin wen = 1'b1; wval = {imm, 16'h0}; end
      6'h23: begin wen = 1'b1; wval = (w < 32'(DM_DEPTH)) ? m_dm[int'(w)] : 32'h0; end
      6'h2B: if (w < 32'(DM_DEPTH)) m_dm[int'(w)] = b;
      6'h04: if (a == b) nxt = m_pc + 32'd4 + (simm << 2);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (wen && widx != 5'd0) m_rf[widx] = wval;
    m_pc = nxt;
  endtask

  // Called at a sampling point: compares PC, then advances the model one instruction
  task automatic run_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      check32($sformatf("%s pc[%0d]", tag, k), dut.PC, m_pc);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 32; i++)
      check32($sformatf("%s rf[%0d]", tag, i), dut.regFile.rf[i], m_rf[i]);
    for (int i = 0; i < 64; i++)
      check32($sformatf("%s dmem[%0d]", tag, i), dut.dataMem.innerDM.dmem[i], m_dm[i]);
  endtask

  // Holds reset across one edge while the new image is loaded
  task automatic start_program(input logic [31:0] words[$]);
    rst = 1'b0;
    for (int i = 0; i < IM_DEPTH; i++) begin
      prog[i] = (i < words.size()) ? words[i] : 32'h0;
      dut.insMem.innerIM.ROM[i] <= prog[i];
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs = 5'($urandom_range(0, 7));
    logic [4:0]  rt = 5'($urandom_range(0, 7));
    logic [4:0]  rd = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    logic [15:0] off = 16'(4 * $urandom_range(0, 63));
    case ($urandom_range(0, 15))
      0:  return enc_r(6'h20, rs, rt, rd);
      1:  return enc_r(6'h22, rs, rt, rd);
      2:  return enc_r(6'h24, rs, rt, rd);
      3:  return enc_r(6'h25, rs, rt, rd);
      4:  return enc_r(6'h2A, rs, rt, rd);
      5:  return enc_i(6'h08, rs, rt, imm);
      6:  return enc_i(6'h0C, rs, rt, imm);
      7:  return enc_i(6'h0D, rs, rt, imm);
      8:  return enc_i(6'h0F, 5'd0, rt, imm);
      9:  return enc_i(6'h23, 5'd0, rt, off);
      10: return enc_i(6'h2B, 5'd0, rt, off);
      11: return enc_i(($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B, rs, rt, imm);
      12: return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
      13: return enc_i(6'h04, rs, rs, 16'($urandom_range(0, 2)));
      14: return {6'h3F, 26'($urandom)};
      default: return enc_r(6'h21, rs, rt, rd);
    endcase
  endfunction

  initial begin
    logic [31:0] q[$];
    rst = 1'b0;
    for (int i = 0; i < DM_DEPTH; i++) begin
      dut.dataMem.innerDM.dmem[i] <= 32'h0;
      m_dm[i] = 32'h0;
    end
    repeat (3) @(negedge clk);

    // Reset state with the clock running
    check32("reset pc", dut.PC, TEXT_BASE);
    for (int i = 0; i < 32; i++) check32($sformatf("reset rf[%0d]", i), dut.regFile.rf[i], 32'h0);

    // ALU, immediates, load/store, $0 writes, undefined opcode, jump out of ROM
    q = {};
    q.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    q.push_back(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    q.push_back(enc_r(6'h20, 5'd1, 5'd2, 5'd3));
    q.push_back(enc_r(6'h22, 5'd1, 5'd2, 5'd4));
    q.push_back(enc_r(6'h2A, 5'd2, 5'd1, 5'd5));
    q.push_back(enc_r(6'h24, 5'd1, 5'd2, 5'd10));
    q.push_back(enc_r(6'h25, 5'd1, 5'd2, 5'd11));
    q.push_back(enc_i(6'h0D, 5'd0, 5'd6, 16'hFFFF));
    q.push_back(enc_i(6'h0C, 5'd6, 5'd7, 16'h00F0));
    q.push_back(enc_i(6'h0F, 5'd0, 5'd8, 16'h1234));
    q.push_back(enc_i(6'h2B, 5'd0, 5'd1, 16'd80));
    q.push_back(enc_i(6'h23, 5'd0, 5'd9, 16'd80));
    q.push_back(enc_i(6'h2B, 5'd0, 5'd2, 16'd84));
    q.push_back(enc_i(6'h08, 5'd0, 5'd0, 16'd7));
    q.push_back(32'hFC00_0000);
    q.push_back(enc_r(6'h20, 5'd1, 5'd1, 5'd1));
    q.push_back(enc_r(6'h2A, 5'd1, 5'd2, 5'd12));
    q.push_back(enc_j(26'd0));
    start_program(q);
    run_cycles(22, "dir");
    check32("dir add", dut.regFile.rf[3], 32'd2);
    check32("dir sub", dut.regFile.rf[4], 32'd8);
    check32("dir slt", dut.regFile.rf[5], 32'd1);
    check32("dir and", dut.regFile.rf[10], 32'h0000_0005);
    check32("dir or", dut.regFile.rf[11], 32'hFFFF_FFFD);
    check32("dir ori", dut.regFile.rf[6], 32'h0000_FFFF);
    check32("dir andi", dut.regFile.rf[7], 32'h0000_00F0);
    check32("dir lui", dut.regFile.rf[8], 32'h1234_0000);
    check32("dir lw", dut.regFile.rf[9], 32'd5);
    check32("dir r0", dut.regFile.rf[0], 32'h0);
    check32("dir self add", dut.regFile.rf[1], 32'd10);
    check32("dir slt signed", dut.regFile.rf[12], 32'd0);
    check32("dir dmem20", dut.dataMem.innerDM.dmem[20], 32'd5);
    check32("dir dmem21", dut.dataMem.innerDM.dmem[21], 32'hFFFF_FFFD);
    check32("dir pc oob", dut.PC, 32'h0000_0010);
    check_state("dir");

    // Counting loop: sum 1..10 via beq/j
    q = {};
    q.push_back(enc_i(6'h08, 5'd0, 5'd1, 16'd0));
    q.push_back(enc_i(6'h08, 5'd0, 5'd2, 16'd0));
    q.push_back(enc_i(6'h08, 5'd0, 5'd3, 16'd10));
    q.push_back(enc_i(6'h04, 5'd2, 5'd3, 16'd3));
    q.push_back(enc_i(6'h08, 5'd2, 5'd2, 16'd1));
    q.push_back(enc_r(6'h20, 5'd1, 5'd2, 5'd1));
    q.push_back(enc_j(26'h0000C03));
    q.push_back(enc_i(6'h2B, 5'd0, 5'd1, 16'd80));
    q.push_back(enc_i(6'h2B, 5'd0, 5'd2, 16'd84));
    start_program(q);
    run_cycles(50, "loop");
    check32("loop sum", dut.dataMem.innerDM.dmem[20], 32'd55);
    check32("loop count", dut.dataMem.innerDM.dmem[21], 32'd10);
    check32("loop pc", dut.PC, 32'h0000_3034);
    check_state("loop");

    // Random program with an asynchronous reset between clock edges
    q = {};
    for (int i = 0; i < 60; i++) q.push_back(rand_inst());
    start_program(q);
    run_cycles(30, "rnd1a");
    #2 rst = 1'b0;
    #1;
    check32("async reset pc", dut.PC, TEXT_BASE);
    for (int i = 1; i < 8; i++) check32($sformatf("async reset rf[%0d]", i), dut.regFile.rf[i], 32'h0);
    model_reset();
    #1 rst = 1'b1;
    run_cycles(70, "rnd1b");
    check_state("rnd1");

    q = {};
    for (int i = 0; i < 60; i++) q.push_back(rand_inst());
    start_program(q);
    run_cycles(80, "rnd2");
    check_state("rnd2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
